// File: rtl/xor_cipher_cfg_loader.sv
// xor_cipher_cfg_loader: shifts a parallel key MSB-first into the cipher chain.
// Define XOR_CIPHER_CFG_VERIFY_EN to add a read-back verify pass and live err.
module xor_cipher_cfg_loader #(
    parameter int M = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [M-1:0] key_i,
    input  logic         cfg_o,
    output logic         cfg_en,
    output logic         cfg_i,
    output logic         busy,
    output logic         done,
    output logic [M-1:0] key_o,
    output logic         err
);
    localparam int CW = $clog2(M + 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] SHIFT = 2'd1;
`ifdef XOR_CIPHER_CFG_VERIFY_EN
    localparam logic [1:0] VERIFY = 2'd2;
`endif
    localparam logic [1:0] DONE  = 2'd3;

    localparam logic [CW-1:0] LAST = CW'(M - 1);

    logic [1:0]    state;
    logic [1:0]    state_n;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_n;
    logic [M-1:0]  key_sr;
    logic [M-1:0]  key_sr_n;
    logic [M-1:0]  cap_sr;
    logic          cnt_last;
    logic          shifting_n;

    assign cnt_last = (cnt == LAST);

    // key_sr rotates so the latched key is intact again after every M-cycle pass
    always_comb begin
        state_n  = state;
        cnt_n    = cnt;
        key_sr_n = key_sr;
        unique case (state)
            IDLE: begin
                if (start) begin
                    state_n  = SHIFT;
                    cnt_n    = '0;
                    key_sr_n = key_i;
                end
            end
            SHIFT: begin
                key_sr_n = {key_sr[M-2:0], key_sr[M-1]};
                if (cnt_last) begin
                    cnt_n   = '0;
`ifdef XOR_CIPHER_CFG_VERIFY_EN
                    state_n = VERIFY;
`else
                    state_n = DONE;
`endif
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`ifdef XOR_CIPHER_CFG_VERIFY_EN
            VERIFY: begin
                key_sr_n = {key_sr[M-2:0], key_sr[M-1]};
                if (cnt_last) begin
                    cnt_n   = '0;
                    state_n = DONE;
                end else begin
                    cnt_n = cnt + CW'(1);
                end
            end
`endif
            DONE: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

`ifdef XOR_CIPHER_CFG_VERIFY_EN
    assign shifting_n = (state_n == SHIFT) || (state_n == VERIFY);
`else
    assign shifting_n = (state_n == SHIFT);
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            key_sr <= '0;
            cap_sr <= '0;
            key_o  <= '0;
            cfg_en <= 1'b0;
            cfg_i  <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_n;
            cnt    <= cnt_n;
            key_sr <= key_sr_n;
            cfg_en <= shifting_n;
            cfg_i  <= shifting_n & key_sr_n[M-1];
            busy   <= (state_n != IDLE);
            done   <= (state_n == DONE);
            if (state == SHIFT) begin
                cap_sr <= {cap_sr[M-2:0], cfg_o};
                if (cnt_last)
                    key_o <= {cap_sr[M-2:0], cfg_o};
            end
        end
    end

`ifdef XOR_CIPHER_CFG_VERIFY_EN
    // the chain already holds the key, so cfg_o must echo the bit being driven
    always_ff @(posedge clk) begin
        if (rst)
            err <= 1'b0;
        else if (state == IDLE && start)
            err <= 1'b0;
        else if (state == VERIFY && cfg_o != cfg_i)
            err <= 1'b1;
    end
`else
    assign err = 1'b0;
`endif

endmodule
